// File: rtl/pipe_pkg.sv
// Shared pipeline constants and types: data/address widths, register count,
// and the hardwired-zero register address.
package pipe_pkg;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int REG_N  = 32;

   typedef logic [DATA_W-1:0] word_t;
   typedef logic [ADDR_W-1:0] regaddr_t;

   localparam regaddr_t REG_ZERO = '0;
endpackage

// File: rtl/wb_regfile_if.sv
// Writeback/decode bundle of the register file: WB-stage write request,
// two decode read ports, the selected result and the commit counter.
interface wb_regfile_if;
   import pipe_pkg::*;

   logic        regwriteW;
   logic        memtoregW;
   word_t       aluoutW;
   word_t       readdataW;
   regaddr_t    writeregW;
   regaddr_t    ra1D;
   regaddr_t    ra2D;
   word_t       rd1D;
   word_t       rd2D;
   word_t       resultW;
   logic [31:0] wrcountW;

   modport master (
      output regwriteW, memtoregW, aluoutW, readdataW, writeregW, ra1D, ra2D,
      input  rd1D, rd2D, resultW, wrcountW
   );

   modport slave (
      input  regwriteW, memtoregW, aluoutW, readdataW, writeregW, ra1D, ra2D,
      output rd1D, rd2D, resultW, wrcountW
   );
endinterface

// File: rtl/wb_regfile_rdport.sv
// One decode read port: zero register, same-cycle write bypass, array mux.
// Purely combinational, zero latency; no backpressure.
module wb_regfile_rdport
   import pipe_pkg::*;
(
   input  word_t    regs [REG_N],
   input  logic     byp_en,
   input  regaddr_t wa,
   input  word_t    wd,
   input  regaddr_t ra,
   output word_t    rd
);

   always_comb begin
      rd = regs[ra];
      if (ra == REG_ZERO) begin
         rd = '0;
      end else if (byp_en && (wa == ra)) begin
         rd = wd;
      end
   end

endmodule

// File: rtl/wb_regfile.sv
// Writeback result select, 32x32 register file with write-to-read bypass, commit counter.
// Reads and resultW are combinational; writes land on the next rising edge; no backpressure.
module wb_regfile
   import pipe_pkg::*;
(
   input  logic         clk,
   input  logic         reset_n,
   wb_regfile_if.slave  bus
);

   word_t       regs [REG_N];
   logic [31:0] wrcount_q;
   word_t       result;
   logic        commit;
   logic        byp_en;

   assign result = bus.memtoregW ? bus.readdataW : bus.aluoutW;
   assign byp_en = reset_n & bus.regwriteW;
   // Register 0 is never written, so it stays at its reset value of zero.
   assign commit = byp_en & (bus.writeregW != REG_ZERO);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < REG_N; i++) begin
            regs[i] <= '0;
         end
         wrcount_q <= '0;
      end else if (commit) begin
         regs[bus.writeregW] <= result;
         wrcount_q           <= wrcount_q + 32'd1;
      end
   end

   wb_regfile_rdport u_rd1 (
      .regs   (regs),
      .byp_en (byp_en),
      .wa     (bus.writeregW),
      .wd     (result),
      .ra     (bus.ra1D),
      .rd     (bus.rd1D)
   );

   wb_regfile_rdport u_rd2 (
      .regs   (regs),
      .byp_en (byp_en),
      .wa     (bus.writeregW),
      .wd     (result),
      .ra     (bus.ra2D),
      .rd     (bus.rd2D)
   );

   assign bus.resultW  = result;
   assign bus.wrcountW = wrcount_q;

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
Writeback-stage register file for the 5-stage MIPS pipeline. It sits at the consuming end of the MEM/WB pipeline register.
- Selects the writeback result from the WB-stage ALU output and memory read data.
- Commits the result to a 32x32 architectural register file.
- Serves the two decode-stage read ports, with a same-cycle write-to-read bypass so Decode sees the value being written this cycle.
- Keeps a count of committed register writes for debug and performance monitoring.

Parameters:
- DATA_W, 32, register and data width in bits.
- REG_N, 32, number of architectural registers.
- ADDR_W, 5, register address width; REG_N must equal 2**ADDR_W.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- regwriteW  in  1  WB-stage register-write enable.
- memtoregW  in  1  WB-stage result select: 1 = readdataW, 0 = aluoutW.
- aluoutW  in  DATA_W  WB-stage ALU result.
- readdataW  in  DATA_W  WB-stage memory load data.
- writeregW  in  ADDR_W  WB-stage destination register.
- ra1D  in  ADDR_W  decode read address, port 1.
- ra2D  in  ADDR_W  decode read address, port 2.
- rd1D  out  DATA_W  decode read data, port 1.
- rd2D  out  DATA_W  decode read data, port 2.
- resultW  out  DATA_W  selected writeback value, also used by the hazard/forwarding logic.
- wrcountW  out  32  number of committed register writes.

Behaviour:
- Reset is synchronous and active-low. On a rising clk edge with reset_n=0:
  - all REG_N registers clear to 0;
  - wrcountW clears to 0;
  - any write presented in that cycle is discarded.
- resultW is combinational: memtoregW ? readdataW : aluoutW. It is valid in every cycle, including reset cycles, and does not depend on regwriteW.
- A write commits only when all of these hold at the rising edge: reset_n=1, regwriteW=1, writeregW != 0.
  - The committed value is resultW.
  - The write is visible in the array from the following cycle onward.
- Register 0 is hardwired to zero:
  - writes to it are dropped and are not counted;
  - reads of it always return 0, including under bypass.
- Reads are combinational with zero latency. For each port (rdXD / raXD):
  - raXD == 0 -> 0.
  - Else if reset_n=1, regwriteW=1 and writeregW == raXD -> resultW (bypass of the same-cycle write).
  - Else -> array[raXD].
- While reset_n=0 the bypass is disabled and reads return the current array contents.
- Both ports are fully independent. ra1D == ra2D is legal; both ports return identical data, including when bypassed.
- wrcountW increments by exactly 1 on each committed write and wraps 0xFFFFFFFF -> 0 with no flag.
- Back-to-back writes to the same register: the last one wins, and each write is counted.
- Writes do not depend on read addresses. A read and a write to different registers in the same cycle do not interact.
- X on regwriteW when reset_n=1 is a protocol violation; no protection is required.

Decomposition:
- Shared package pipe_pkg holds:
  - DATA_W, ADDR_W and REG_N constants;
  - the typedefs word_t (logic [DATA_W-1:0]) and regaddr_t (logic [ADDR_W-1:0]);
  - the constant REG_ZERO = '0.
- One sub-module is natural: wb_regfile_rdport, one instance per read port. It contains the zero check, the bypass compare and the array mux, so both ports are guaranteed identical.
- The result mux, write logic, array and counter stay in wb_regfile.

Test Plan:
1. Reset clear: preload registers with writes, hold reset_n=0 for 1 cycle -> every register reads 0 and wrcountW=0. A write presented during the reset cycle (reg 5, 0xDEADBEEF) is not committed.
2. Basic write/read: regwriteW=1, memtoregW=0, aluoutW=0x00001234, writeregW=8. Next cycle, ra1D=8 -> rd1D=0x00001234 and wrcountW=1.
3. Result select and bypass: memtoregW=1, readdataW=0xCAFEF00D, aluoutW=0x11111111, writeregW=9, ra1D=ra2D=9 in the same cycle -> resultW, rd1D and rd2D all equal 0xCAFEF00D in that cycle.
4. Register 0: write 0xFFFFFFFF to writeregW=0 with ra1D=0 in the same cycle -> rd1D=0 in that cycle and the next; wrcountW unchanged.
5. regwriteW=0 with writeregW=3 and aluoutW=0xAAAA5555, ra2D=3 -> rd2D keeps the old value (no bypass); reg 3 unchanged afterwards; count unchanged.
6. Counter wrap: force wrcountW to 0xFFFFFFFF via 2^32-1 writes or a bench force, then commit one write -> wrcountW=0. Two consecutive writes to reg 4 (0x1, then 0x2) -> reg 4 reads 0x2 and the count increases by 2.
